// File: rtl/field_extract_if.sv
// Read-side request/response bundle between the CPU operand path and the
// field extractor. The master drives the read request, stall and bank data;
// the slave returns the extracted field.
interface field_extract_if;
  logic        data_hazard;
  logic [15:0] bus_in;
  logic        bus_load;
  logic        latch_address_r;
  logic [2:0]  R0;
  logic [2:0]  L_select;
  logic        rd_req;
  logic [7:0]  data_out;
  logic        data_valid;

  modport master (
    output data_hazard, bus_in, bus_load, latch_address_r, R0, L_select, rd_req,
    input  data_out, data_valid
  );

  modport slave (
    input  data_hazard, bus_in, bus_load, latch_address_r, R0, L_select, rd_req,
    output data_out, data_valid
  );
endinterface

// File: rtl/field_extract.sv
// Field extractor: captures {LBD,RBD} bank data, picks one bank, rotates the
// addressed field down to bit 0 and masks it to L bits. Two pipeline stages,
// all registers frozen by data_hazard.
module field_extract (
  input  logic            clk,
  input  logic            rst,
  field_extract_if.slave  io_fx
);
  localparam int STAGES = 2;

  // Stage-1 payload: selected source byte plus the field descriptor.
  typedef struct packed {
    logic [7:0] src;
    logic [2:0] r0;
    logic [2:0] len;
  } s1_t;

  logic [7:0]        r_lbd;
  logic [7:0]        r_rbd;
  s1_t               r_s1;
  logic [7:0]        r_data_out;
  logic [STAGES:1]   r_vld_pipe;
  logic [STAGES:0]   w_vld_pipe;
  s1_t               w_s1_nxt;
  logic [7:0]        w_rot;
  logic [7:0]        w_mask;
  logic [7:0]        w_field;
  logic              w_run;

  // Circular right rotate: result bit i comes from source bit (i+r) mod 8,
  // so fields straddling bit 7 wrap back to source bit 0.
  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] r);
    logic [7:0] y;
    logic [2:0] idx;
    y = '0;
    for (int i = 0; i < 8; i++) begin
      idx  = 3'(i) + r;
      y[i] = x[idx];
    end
    return y;
  endfunction

  // Length 0 encodes a full byte; otherwise L low-order ones.
  function automatic logic [7:0] mask8(input logic [2:0] len);
    return (len == 3'd0) ? 8'hFF : ((8'h01 << len) - 8'h01);
  endfunction

  assign w_run         = !io_fx.data_hazard;
  assign w_vld_pipe    = {r_vld_pipe, io_fx.rd_req};

  // Bank select uses the registered banks, so a same-cycle load is not seen.
  assign w_s1_nxt.src  = io_fx.latch_address_r ? r_rbd : r_lbd;
  assign w_s1_nxt.r0   = io_fx.R0;
  assign w_s1_nxt.len  = io_fx.L_select;

  assign w_rot         = rotr8(r_s1.src, r_s1.r0);
  assign w_mask        = mask8(r_s1.len);
  assign w_field       = w_rot & w_mask;

  // Bank registers: capture read data from the I/O side.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_lbd <= '0;
      r_rbd <= '0;
    end else if (w_run && io_fx.bus_load) begin
      r_lbd <= io_fx.bus_in[15:8];
      r_rbd <= io_fx.bus_in[7:0];
    end
  end

  // Stage 1: latch selected source byte and field descriptor every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1 <= '0;
    end else if (w_run) begin
      r_s1 <= w_s1_nxt;
    end
  end

  // Valid shift register; a stalled rd_req is simply never shifted in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_vld_pipe <= '0;
    end else if (w_run) begin
      r_vld_pipe <= w_vld_pipe[STAGES-1:0];
    end
  end

  // Stage 2: result register; holds its last value when no request is in stage 1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data_out <= '0;
    end else if (w_run && w_vld_pipe[1]) begin
      r_data_out <= w_field;
    end
  end

  assign io_fx.data_out   = r_data_out;
  assign io_fx.data_valid = r_vld_pipe[STAGES];
endmodule

// File: tb/tb_field_extract.sv
// Directed bench for field_extract: table of single reads plus hand-written
// sequences for back-to-back, collision, stall and reset cases.
module tb_field_extract;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  field_extract_if fx();

  field_extract dut (
    .clk   (clk),
    .rst   (rst),
    .io_fx (fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bus;
    logic        bank;
    logic [2:0]  r0;
    logic [2:0]  len;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h, want %02h", name, act, exp);
    end
  endtask

  task automatic idle();
    fx.bus_load = 1'b0;
    fx.rd_req   = 1'b0;
  endtask

  task automatic req(input logic bank, input logic [2:0] r0, input logic [2:0] len);
    fx.rd_req          = 1'b1;
    fx.latch_address_r = bank;
    fx.R0              = r0;
    fx.L_select        = len;
  endtask

  task automatic load(input logic [15:0] d);
    fx.bus_load = 1'b1;
    fx.bus_in   = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0] = '{16'h00B4, 1'b1, 3'd2, 3'd3, 8'h05};
    vecs[1] = '{16'hA55A, 1'b0, 3'd0, 3'd0, 8'hA5};
    vecs[2] = '{16'hA55A, 1'b1, 3'd0, 3'd0, 8'h5A};
    vecs[3] = '{16'h0081, 1'b1, 3'd7, 3'd2, 8'h03};
    vecs[4] = '{16'h0081, 1'b1, 3'd7, 3'd1, 8'h01};
    vecs[5] = '{16'h3C00, 1'b0, 3'd2, 3'd4, 8'h0F};
    vecs[6] = '{16'h00F0, 1'b1, 3'd4, 3'd0, 8'h0F};
    vecs[7] = '{16'h9600, 1'b0, 3'd5, 3'd5, 8'h14};

    rst = 1'b0;
    fx.data_hazard = 1'b0;
    fx.bus_in = '0;
    fx.latch_address_r = 1'b0;
    fx.R0 = '0;
    fx.L_select = '0;
    idle();
    step();
    step();
    chk("reset_data", fx.data_out, 8'h00);
    chk("reset_valid", {7'd0, fx.data_valid}, 8'h00);
    rst = 1'b1;

    // Table: load, request next cycle, result one edge after the request.
    for (int i = 0; i < 8; i++) begin
      load(vecs[i].bus);
      step();
      idle();
      req(vecs[i].bank, vecs[i].r0, vecs[i].len);
      step();
      idle();
      step();
      chk($sformatf("vec%0d_data", i), fx.data_out, vecs[i].exp);
      chk($sformatf("vec%0d_valid", i), {7'd0, fx.data_valid}, 8'h01);
      step();
      chk($sformatf("vec%0d_hold", i), fx.data_out, vecs[i].exp);
      chk($sformatf("vec%0d_drop", i), {7'd0, fx.data_valid}, 8'h00);
    end

    // Back-to-back reads, LBD then RBD.
    load(16'hA55A);
    step();
    idle();
    req(1'b0, 3'd0, 3'd0);
    step();
    req(1'b1, 3'd0, 3'd0);
    step();
    idle();
    chk("b2b_first", fx.data_out, 8'hA5);
    chk("b2b_first_v", {7'd0, fx.data_valid}, 8'h01);
    step();
    chk("b2b_second", fx.data_out, 8'h5A);
    chk("b2b_second_v", {7'd0, fx.data_valid}, 8'h01);
    step();
    chk("b2b_end_v", {7'd0, fx.data_valid}, 8'h00);

    // Load/read collision returns the old bank.
    load(16'h0011);
    step();
    load(16'h0022);
    req(1'b1, 3'd0, 3'd0);
    step();
    fx.bus_load = 1'b0;
    req(1'b1, 3'd0, 3'd0);
    step();
    idle();
    chk("coll_old", fx.data_out, 8'h11);
    step();
    chk("coll_new", fx.data_out, 8'h22);
    chk("coll_new_v", {7'd0, fx.data_valid}, 8'h01);

    // Stall with a request in stage 1; stalled rd_req and bus_load dropped.
    load(16'h00C3);
    step();
    idle();
    req(1'b1, 3'd4, 3'd0);
    step();
    chk("pre_stall_data", fx.data_out, 8'h22);
    chk("pre_stall_v", {7'd0, fx.data_valid}, 8'h00);
    fx.data_hazard = 1'b1;
    req(1'b0, 3'd0, 3'd0);
    load(16'hFFFF);
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall%0d_data", c), fx.data_out, 8'h22);
      chk($sformatf("stall%0d_v", c), {7'd0, fx.data_valid}, 8'h00);
    end
    fx.data_hazard = 1'b0;
    idle();
    step();
    chk("post_stall_data", fx.data_out, 8'h3C);
    chk("post_stall_v", {7'd0, fx.data_valid}, 8'h01);
    step();
    chk("stall_req_dropped", {7'd0, fx.data_valid}, 8'h00);
    req(1'b1, 3'd0, 3'd0);
    step();
    idle();
    step();
    chk("stall_load_dropped", fx.data_out, 8'hC3);

    // Reset with two requests in flight.
    load(16'h7777);
    step();
    idle();
    req(1'b0, 3'd0, 3'd0);
    step();
    req(1'b1, 3'd0, 3'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_data", fx.data_out, 8'h00);
    chk("rst_v", {7'd0, fx.data_valid}, 8'h00);
    rst = 1'b1;
    idle();
    step();
    chk("rst_after_v", {7'd0, fx.data_valid}, 8'h00);
    req(1'b1, 3'd0, 3'd0);
    step();
    idle();
    step();
    chk("rst_bank_data", fx.data_out, 8'h00);
    chk("rst_bank_v", {7'd0, fx.data_valid}, 8'h01);
    req(1'b0, 3'd0, 3'd0);
    step();
    idle();
    step();
    chk("rst_lbd_data", fx.data_out, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
